// File: rtl/uart_loader.sv
// UART boot loader: receives a sync/length/data/checksum frame on rx_i and writes
// each 32-bit word to the bus from BASE_ADDR upward while holding the CPU halted.
module uart_loader #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    output logic        m_req_o,
    output logic        m_we_o,
    input  logic        m_gnt_i,
    output logic        halt_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned DIV  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int          CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_t;

    logic            rx_meta, rx_sync, rx_prev;
    rx_state_t       rx_state, rx_state_next;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_tick;
    logic            byte_stb, frame_err;
    logic [7:0]      byte_data;

    state_t          state, state_next;
    logic [15:0]     count, index;
    logic [7:0]      csum;
    logic [31:0]     word;
    logic [1:0]      byte_idx;
    logic            buf_valid;
    logic [7:0]      buf_data;
    logic            done_q, err_q;
    logic            use_buf, have_byte, consume, xfer, last_word;
    logic [7:0]      cur_byte;

    // Receiver: start is checked at mid-bit, later bits every DIV cycles from there
    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == DIV_LAST);

    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_state_next = RX_START;
            RX_START: if (rx_tick) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_state_next = RX_IDLE;
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            byte_data <= '0;
        end else begin
            rx_meta   <= rx_i;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            rx_state  <= rx_state_next;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            if (rx_state == RX_IDLE || rx_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + CW'(1);
            if (rx_state == RX_START)
                rx_bit <= '0;
            if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            if (rx_state == RX_STOP && rx_tick) begin
                if (rx_sync) begin
                    byte_stb  <= 1'b1;
                    byte_data <= rx_shift;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    // A byte parked during WRITE is consumed ahead of any newly arriving one
    assign use_buf   = buf_valid && (state != WRITE);
    assign have_byte = use_buf || (byte_stb && state != WRITE);
    assign cur_byte  = use_buf ? buf_data : byte_data;
    assign consume   = have_byte && (state inside {LEN0, LEN1, DATA, CSUM});
    assign xfer      = (state == WRITE) && m_gnt_i;
    assign last_word = (index + 16'd1) == count;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (have_byte && cur_byte == 8'hA5) state_next = LEN0;
            LEN0:  if (have_byte) state_next = LEN1;
            LEN1:  if (have_byte) state_next = ({cur_byte, count[7:0]} != 16'd0) ? DATA : CSUM;
            DATA:  if (have_byte && byte_idx == 2'd3) state_next = WRITE;
            WRITE: begin
                if (byte_stb && buf_valid)
                    state_next = ERR;
                else if (xfer)
                    state_next = last_word ? CSUM : DATA;
            end
            CSUM:  if (have_byte) state_next = (cur_byte == csum) ? DONE : ERR;
            DONE:  state_next = IDLE;
            ERR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (frame_err && state != IDLE)
            state_next = ERR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            index     <= '0;
            csum      <= '0;
            word      <= '0;
            byte_idx  <= '0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state == IDLE && state_next == LEN0) begin
                done_q   <= 1'b0;
                err_q    <= 1'b0;
                csum     <= '0;
                index    <= '0;
                byte_idx <= '0;
            end
            if (consume && state != CSUM)
                csum <= csum ^ cur_byte;
            if (consume && state == LEN0)
                count[7:0] <= cur_byte;
            if (consume && state == LEN1)
                count[15:8] <= cur_byte;
            if (consume && state == DATA) begin
                word[{byte_idx, 3'b000} +: 8] <= cur_byte;
                byte_idx <= byte_idx + 2'd1;
            end
            if (xfer)
                index <= index + 16'd1;

            if (state == WRITE && byte_stb) begin
                buf_valid <= 1'b1;
                buf_data  <= byte_data;
            end else if (use_buf) begin
                if (byte_stb)
                    buf_data <= byte_data;
                else
                    buf_valid <= 1'b0;
            end
            if (state == DONE || state == ERR)
                buf_valid <= 1'b0;

            if (state_next == DONE && state != DONE)
                done_q <= 1'b1;
            if (state_next == ERR && state != ERR)
                err_q <= 1'b1;
        end
    end

    assign m_req_o  = (state == WRITE);
    assign m_we_o   = (state == WRITE);
    assign m_addr_o = (state == WRITE) ? (BASE_ADDR + {14'd0, index, 2'b00}) : 32'd0;
    assign m_data_o = (state == WRITE) ? word : 32'd0;
    assign halt_o   = state inside {LEN0, LEN1, DATA, WRITE, CSUM};
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: table of whole frames plus hand-written
// sequences for glitch, framing error, overrun and mid-frame reset.
module tb_uart_loader;

    localparam int BIT_NS = 100;

    logic        clk;
    logic        rst;
    logic        rx_i;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic        m_req_o;
    logic        m_we_o;
    logic        m_gnt_i;
    logic        halt_o;
    logic        done_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    int          wr_count;
    logic [31:0] exp_addr [2];
    logic [31:0] exp_data [2];
    int          stall_cycles;
    logic        gnt_idle;
    int          stall_cnt;

    typedef struct packed {
        logic [95:0] frame;
        int          n;
        int          stall;
        logic        idle_gnt;
        int          exp_n;
        logic [31:0] addr0;
        logic [31:0] data0;
        logic [31:0] addr1;
        logic [31:0] data1;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs [5];

    uart_loader #(
        .CLK_FREQ (1000000),
        .BAUD     (100000),
        .BASE_ADDR(32'h0000_1000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_i    (rx_i),
        .m_addr_o(m_addr_o),
        .m_data_o(m_data_o),
        .m_req_o (m_req_o),
        .m_we_o  (m_we_o),
        .m_gnt_i (m_gnt_i),
        .halt_o  (halt_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant driver: holds grant low for stall_cycles after each request rises
    initial begin
        m_gnt_i   = 1'b0;
        stall_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!m_req_o) begin
                stall_cnt = 0;
                m_gnt_i   = gnt_idle;
            end else if (stall_cnt < stall_cycles) begin
                m_gnt_i = 1'b0;
                stall_cnt++;
            end else begin
                m_gnt_i = 1'b1;
            end
        end
    end

    // Every requesting cycle must present the expected address/data of the pending word
    always @(negedge clk) begin
        if (rst && m_req_o) begin
            if (wr_count < 2) begin
                checkOutput("wr_addr", m_addr_o, exp_addr[wr_count]);
                checkOutput("wr_data", m_data_o, exp_data[wr_count]);
            end
            checkOutput("wr_we", {31'd0, m_we_o}, 32'd1);
            if (m_gnt_i)
                wr_count++;
        end
    end

    task automatic sendByte(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            #(BIT_NS);
        end
        rx_i = stop;
        #(BIT_NS);
        rx_i = 1'b1;
        #(BIT_NS);
    endtask

    task automatic setExpect(input int s, input logic g, input logic [31:0] a0,
                             input logic [31:0] d0, input logic [31:0] a1, input logic [31:0] d1);
        stall_cycles = s;
        gnt_idle     = g;
        exp_addr[0]  = a0;
        exp_data[0]  = d0;
        exp_addr[1]  = a1;
        exp_data[1]  = d1;
        wr_count     = 0;
    endtask

    task automatic checkIdleFlags(input string tag, input logic d, input logic e);
        checkOutput({tag, "_done"}, {31'd0, done_o}, {31'd0, d});
        checkOutput({tag, "_err"},  {31'd0, err_o},  {31'd0, e});
        checkOutput({tag, "_halt"}, {31'd0, halt_o}, 32'd0);
        checkOutput({tag, "_req"},  {31'd0, m_req_o}, 32'd0);
    endtask

    task automatic applyStimulus(input int k, input vec_t v);
        logic       synced;
        logic [7:0] b;
        string      tag;
        tag = $sformatf("vec%0d", k);
        synced = 1'b0;
        setExpect(v.stall, v.idle_gnt, v.addr0, v.data0, v.addr1, v.data1);
        for (int i = 0; i < v.n; i++) begin
            b = v.frame[95 - 8*i -: 8];
            sendByte(b, 1'b1);
            if (b == 8'hA5)
                synced = 1'b1;
            checkOutput($sformatf("%s_halt_b%0d", tag, i), {31'd0, halt_o},
                        {31'd0, synced && (i < v.n - 1)});
        end
        #(BIT_NS);
        checkIdleFlags(tag, v.exp_done, v.exp_err);
        checkOutput({tag, "_writes"}, wr_count, v.exp_n);
    endtask

    initial begin
        // Checksum is the XOR of length and data bytes: 02^13^93^10 = 0x92 and 01^78^56^34^12 = 0x09
        vecs[0] = '{frame: {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92},
                    n: 12, stall: 0, idle_gnt: 1'b1, exp_n: 2,
                    addr0: 32'h1000, data0: 32'h0000_0013, addr1: 32'h1004, data1: 32'h0010_0093,
                    exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = vecs[0];
        vecs[1].stall    = 7;
        vecs[1].idle_gnt = 1'b0;
        vecs[2] = vecs[0];
        vecs[2].frame[7:0] = 8'h00;
        vecs[2].exp_done   = 1'b0;
        vecs[2].exp_err    = 1'b1;
        vecs[3] = '{frame: {8'hA5, 8'h00, 8'h00, 8'h00, 64'd0},
                    n: 4, stall: 0, idle_gnt: 1'b1, exp_n: 0,
                    addr0: 32'h1000, data0: 32'h0, addr1: 32'h1004, data1: 32'h0,
                    exp_done: 1'b1, exp_err: 1'b0};
        vecs[4] = '{frame: {8'h3C, 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09, 24'd0},
                    n: 9, stall: 3, idle_gnt: 1'b0, exp_n: 1,
                    addr0: 32'h1000, data0: 32'h1234_5678, addr1: 32'h1004, data1: 32'h0,
                    exp_done: 1'b1, exp_err: 1'b0};

        rst  = 1'b0;
        rx_i = 1'b1;
        setExpect(0, 1'b1, 32'h1000, 32'h0, 32'h1004, 32'h0);
        #22;
        checkOutput("rst_addr", m_addr_o, 32'd0);
        checkOutput("rst_data", m_data_o, 32'd0);
        checkOutput("rst_we",   {31'd0, m_we_o}, 32'd0);
        checkIdleFlags("rst", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #(BIT_NS);

        for (int k = 0; k < 5; k++)
            applyStimulus(k, vecs[k]);

        // Short low pulse while idle must not be taken as a start bit
        setExpect(0, 1'b1, 32'h1000, 32'h0, 32'h1004, 32'h0);
        rx_i = 1'b0;
        #30;
        rx_i = 1'b1;
        #(20 * BIT_NS);
        checkIdleFlags("glitch", 1'b1, 1'b0);
        checkOutput("glitch_writes", wr_count, 0);
        sendByte(8'hA5, 1'b1);
        checkOutput("glitch_resync_halt", {31'd0, halt_o}, 32'd1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h00, 1'b1);
        #(BIT_NS);
        checkIdleFlags("glitch_frame", 1'b1, 1'b0);

        // Stop bit low during DATA
        setExpect(0, 1'b1, 32'h1000, 32'h0, 32'h1004, 32'h0);
        sendByte(8'hA5, 1'b1);
        sendByte(8'h01, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h13, 1'b1);
        sendByte(8'h56, 1'b0);
        #(BIT_NS);
        checkIdleFlags("framing", 1'b0, 1'b1);
        checkOutput("framing_writes", wr_count, 0);

        // Grant withheld while two more bytes arrive
        setExpect(1000000, 1'b0, 32'h1000, 32'h0000_0013, 32'h1004, 32'h0);
        sendByte(8'hA5, 1'b1);
        sendByte(8'h02, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h13, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h00, 1'b1);
        checkOutput("overrun_req_held", {31'd0, m_req_o}, 32'd1);
        sendByte(8'h93, 1'b1);
        checkOutput("overrun_buffered_halt", {31'd0, halt_o}, 32'd1);
        sendByte(8'h00, 1'b1);
        #(BIT_NS);
        checkIdleFlags("overrun", 1'b0, 1'b1);
        checkOutput("overrun_writes", wr_count, 0);

        // Reset in the middle of a data byte
        setExpect(0, 1'b1, 32'h1000, 32'h1234_5678, 32'h1004, 32'h0);
        sendByte(8'hA5, 1'b1);
        sendByte(8'h01, 1'b1);
        sendByte(8'h00, 1'b1);
        rx_i = 1'b0;
        #(BIT_NS);
        rx_i = 1'b1;
        #(BIT_NS);
        rx_i = 1'b0;
        #50;
        checkOutput("pre_reset_halt", {31'd0, halt_o}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("midrst_addr", m_addr_o, 32'd0);
        checkOutput("midrst_data", m_data_o, 32'd0);
        checkOutput("midrst_we",   {31'd0, m_we_o}, 32'd0);
        checkIdleFlags("midrst", 1'b0, 1'b0);
        #49;
        rx_i = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        rst = 1'b1;
        #(5 * BIT_NS);
        checkOutput("post_reset_halt", {31'd0, halt_o}, 32'd0);
        sendByte(8'hA5, 1'b1);
        sendByte(8'h01, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h78, 1'b1);
        sendByte(8'h56, 1'b1);
        sendByte(8'h34, 1'b1);
        sendByte(8'h12, 1'b1);
        sendByte(8'h09, 1'b1);
        #(BIT_NS);
        checkIdleFlags("after_reset", 1'b1, 1'b0);
        checkOutput("after_reset_writes", wr_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
